// File: rtl/xain_pkg.sv
// Shared types and constants for the SDRAM channel-3 arbiter.
package xain_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} sdr_ch3_state_t;
  typedef enum logic [1:0] {CH3_ROM, CH3_BG2, CH3_MAP} sdr_ch3_id_t;

  localparam logic [15:0] SDR_CH3_TIMEOUT_FILL = 16'hFFFF;

endpackage

// File: rtl/sdr_ch3_arbiter.sv
// SDRAM ch3 sequencer: ROM download writes win outright, BG2/MAP reads are round-robin; one transaction at a time.
// ch3_req one cycle after the grant, rdy one cycle after ch3_ready; SDR_CH3_TIMEOUT_EN adds a WAIT watchdog and err.
module sdr_ch3_arbiter
  import xain_pkg::*;
#(
  parameter int AW      = 25,
  parameter int TIMEOUT = 255
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          download,
  input  logic [AW-1:0] rom_addr,
  input  logic [15:0]   rom_din,
  input  logic [1:0]    rom_be,
  input  logic          rom_req,
  output logic          rom_rdy,
  input  logic [AW-1:0] bg2_addr,
  input  logic          bg2_req,
  output logic [15:0]   bg2_dout,
  output logic          bg2_rdy,
  input  logic [AW-1:0] map_addr,
  input  logic          map_req,
  output logic [15:0]   map_dout,
  output logic          map_rdy,
  input  logic [1:0]    dbg_mask,
  output logic [AW-2:0] ch3_addr,
  output logic [15:0]   ch3_din,
  output logic [1:0]    ch3_be,
  output logic          ch3_rnw,
  output logic          ch3_req,
  input  logic [15:0]   ch3_dout,
  input  logic          ch3_ready,
  output logic          busy,
  output logic          err
);

  sdr_ch3_state_t state_q, state_d;
  sdr_ch3_id_t    id_q, id_d;
  logic           ptr_map_q, ptr_map_d;
  logic [AW-2:0]  addr_q, addr_d;
  logic [15:0]    din_q, din_d;
  logic [1:0]     be_q, be_d;
  logic           rnw_q, rnw_d;
  logic [15:0]    bg2_dout_q, bg2_dout_d;
  logic [15:0]    map_dout_q, map_dout_d;
  logic [15:0]    rdata;
  logic           rom_elig, bg2_elig, map_elig, pick_map;
  logic           timeout_hit;
  logic           unused_lsb;

  assign rom_elig = download & rom_req;
  assign bg2_elig = ~download & bg2_req & ~dbg_mask[0];
  assign map_elig = ~download & map_req & ~dbg_mask[1];
  // MAP wins when it is the only eligible read or the pointer favours it.
  assign pick_map = map_elig & (~bg2_elig | ptr_map_q);

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    ptr_map_d  = ptr_map_q;
    addr_d     = addr_q;
    din_d      = din_q;
    be_d       = be_q;
    rnw_d      = rnw_q;
    bg2_dout_d = bg2_dout_q;
    map_dout_d = map_dout_q;
    rdata      = ch3_ready ? ch3_dout : SDR_CH3_TIMEOUT_FILL;
    case (state_q)
      IDLE: begin
        if (rom_elig) begin
          id_d    = CH3_ROM;
          addr_d  = rom_addr[AW-1:1];
          din_d   = rom_din;
          be_d    = rom_be;
          rnw_d   = 1'b0;
          state_d = ISSUE;
        end else if (bg2_elig | map_elig) begin
          id_d      = pick_map ? CH3_MAP : CH3_BG2;
          addr_d    = pick_map ? map_addr[AW-1:1] : bg2_addr[AW-1:1];
          din_d     = '0;
          be_d      = 2'b11;
          rnw_d     = 1'b1;
          ptr_map_d = ~pick_map;
          state_d   = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (ch3_ready | timeout_hit) begin
          if (rnw_q && id_q == CH3_BG2) bg2_dout_d = rdata;
          if (rnw_q && id_q == CH3_MAP) map_dout_d = rdata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      id_q       <= CH3_BG2;
      ptr_map_q  <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      be_q       <= '0;
      rnw_q      <= 1'b1;
      bg2_dout_q <= '0;
      map_dout_q <= '0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      ptr_map_q  <= ptr_map_d;
      addr_q     <= addr_d;
      din_q      <= din_d;
      be_q       <= be_d;
      rnw_q      <= rnw_d;
      bg2_dout_q <= bg2_dout_d;
      map_dout_q <= map_dout_d;
    end
  end

`ifdef SDR_CH3_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;

  // cnt_q is zero on the first WAIT cycle, so the watchdog fires after exactly TIMEOUT cycles.
  assign timeout_hit = (state_q == WAIT) && (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= (state_q == WAIT) ? cnt_q + 1'b1 : '0;
      if (timeout_hit && !ch3_ready) err_q <= 1'b1;
    end
  end

  assign err        = err_q;
  assign unused_lsb = ^{rom_addr[0], bg2_addr[0], map_addr[0]};
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
  assign unused_lsb  = ^{rom_addr[0], bg2_addr[0], map_addr[0], TIMEOUT};
`endif

  assign ch3_addr = addr_q;
  assign ch3_din  = din_q;
  assign ch3_be   = be_q;
  assign ch3_rnw  = rnw_q;
  assign ch3_req  = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign rom_rdy  = (state_q == DONE) && (id_q == CH3_ROM);
  assign bg2_rdy  = (state_q == DONE) && (id_q == CH3_BG2);
  assign map_rdy  = (state_q == DONE) && (id_q == CH3_MAP);
  assign bg2_dout = bg2_dout_q;
  assign map_dout = map_dout_q;

endmodule

// File: tb/tb_sdr_ch3_arbiter.sv
// Directed self-checking bench for sdr_ch3_arbiter; inputs driven and outputs sampled on the falling edge.
module tb_sdr_ch3_arbiter;

  localparam int AW = 25;

  logic          CLK, RSTn, download;
  logic [AW-1:0] rom_addr, bg2_addr, map_addr;
  logic [15:0]   rom_din, bg2_dout, map_dout, ch3_din, ch3_dout;
  logic [1:0]    rom_be, dbg_mask, ch3_be;
  logic          rom_req, rom_rdy, bg2_req, bg2_rdy, map_req, map_rdy;
  logic [AW-2:0] ch3_addr;
  logic          ch3_rnw, ch3_req, ch3_ready, busy, err;

  int tests = 0;
  int fails = 0;

  sdr_ch3_arbiter #(.AW(AW), .TIMEOUT(16)) dut (
    .CLK(CLK), .RSTn(RSTn), .download(download),
    .rom_addr(rom_addr), .rom_din(rom_din), .rom_be(rom_be), .rom_req(rom_req), .rom_rdy(rom_rdy),
    .bg2_addr(bg2_addr), .bg2_req(bg2_req), .bg2_dout(bg2_dout), .bg2_rdy(bg2_rdy),
    .map_addr(map_addr), .map_req(map_req), .map_dout(map_dout), .map_rdy(map_rdy),
    .dbg_mask(dbg_mask), .ch3_addr(ch3_addr), .ch3_din(ch3_din), .ch3_be(ch3_be),
    .ch3_rnw(ch3_rnw), .ch3_req(ch3_req), .ch3_dout(ch3_dout), .ch3_ready(ch3_ready),
    .busy(busy), .err(err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end

  task automatic do_reset();
    RSTn = 1'b0; download = 1'b0; rom_addr = '0; rom_din = '0; rom_be = '0; rom_req = 1'b0;
    bg2_addr = 25'h0000100; bg2_req = 1'b0; map_addr = 25'h0000200; map_req = 1'b0;
    dbg_mask = 2'b00; ch3_dout = '0; ch3_ready = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
  endtask

  // Returns the number of falling edges until ch3_req is seen, or -1 if it never comes.
  task automatic wait_ch3_req(output int n);
    n = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (ch3_req === 1'b1) begin
        n = i + 1;
        return;
      end
    end
  endtask

  task automatic pulse_ready(input logic [15:0] d);
    ch3_ready = 1'b1; ch3_dout = d;
    @(negedge CLK);
    ch3_ready = 1'b0; ch3_dout = '0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (ch3_req !== 1'b0) begin fails++; $display("FAIL reset_ch3_req: got %b expected 0", ch3_req); end
    tests++; if (ch3_rnw !== 1'b1) begin fails++; $display("FAIL reset_ch3_rnw: got %b expected 1", ch3_rnw); end
    tests++; if ({rom_rdy, bg2_rdy, map_rdy} !== 3'b000) begin fails++; $display("FAIL reset_rdy: got %b expected 000", {rom_rdy, bg2_rdy, map_rdy}); end
    tests++; if ({ch3_addr, ch3_din, ch3_be} !== '0) begin fails++; $display("FAIL reset_ch3_bus: got %h/%h/%b expected 0", ch3_addr, ch3_din, ch3_be); end
    tests++; if ({bg2_dout, map_dout} !== 32'h0) begin fails++; $display("FAIL reset_dout: got %h/%h expected 0000/0000", bg2_dout, map_dout); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b expected 0", err); end
  endtask

  task automatic test_download_write();
    int n;
    logic seen_bg2;
    do_reset();
    download = 1'b1; rom_addr = 25'h0001234; rom_din = 16'hA55A; rom_be = 2'b11; rom_req = 1'b1; bg2_req = 1'b1;
    wait_ch3_req(n);
    tests++; if (n !== 1) begin fails++; $display("FAIL dl_latency: got %0d expected 1", n); end
    tests++; if (ch3_addr !== 24'h00091A) begin fails++; $display("FAIL dl_addr: got %h expected 00091a", ch3_addr); end
    tests++; if ({ch3_rnw, ch3_be, ch3_din} !== {1'b0, 2'b11, 16'hA55A}) begin fails++; $display("FAIL dl_wr_fields: got %b/%b/%h expected 0/11/a55a", ch3_rnw, ch3_be, ch3_din); end
    seen_bg2 = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      seen_bg2 |= bg2_rdy;
    end
    tests++; if ({ch3_req, busy, ch3_addr} !== {1'b0, 1'b1, 24'h00091A}) begin fails++; $display("FAIL dl_wait_hold: got req=%b busy=%b addr=%h expected 0/1/00091a", ch3_req, busy, ch3_addr); end
    pulse_ready(16'h0000);
    tests++; if ({rom_rdy, bg2_rdy, map_rdy} !== 3'b100) begin fails++; $display("FAIL dl_rom_rdy: got %b expected 100", {rom_rdy, bg2_rdy, map_rdy}); end
    rom_req = 1'b0;
    @(negedge CLK);
    tests++; if ({rom_rdy, busy} !== 2'b00) begin fails++; $display("FAIL dl_rdy_single: got rdy=%b busy=%b expected 0/0", rom_rdy, busy); end
    repeat (4) begin
      @(negedge CLK);
      seen_bg2 |= bg2_rdy | busy;
    end
    tests++; if (seen_bg2 !== 1'b0) begin fails++; $display("FAIL dl_bg2_blocked: got activity=%b expected 0", seen_bg2); end
    bg2_req = 1'b0; download = 1'b0;
  endtask

  task automatic test_round_robin();
    int n;
    logic [15:0] d [3];
    logic exp_map;
    d[0] = 16'h1111; d[1] = 16'h2222; d[2] = 16'h3333;
    do_reset();
    bg2_req = 1'b1; map_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_map = (i == 1);
      wait_ch3_req(n);
      tests++; if (n < 0) begin fails++; $display("FAIL rr_req_%0d: got no ch3_req expected one", i); end
      tests++; if ({ch3_rnw, ch3_addr} !== {1'b1, exp_map ? 24'h000100 : 24'h000080}) begin fails++; $display("FAIL rr_grant_%0d: got rnw=%b addr=%h expected 1/%h", i, ch3_rnw, ch3_addr, exp_map ? 24'h000100 : 24'h000080); end
      repeat (2) @(negedge CLK);
      pulse_ready(d[i]);
      tests++; if ({bg2_rdy, map_rdy} !== {~exp_map, exp_map}) begin fails++; $display("FAIL rr_rdy_%0d: got %b expected %b", i, {bg2_rdy, map_rdy}, {~exp_map, exp_map}); end
      if (exp_map) map_req = 1'b0; else bg2_req = 1'b0;
      if (i == 2) map_req = 1'b0;
      else begin
        @(negedge CLK);
        bg2_req = 1'b1; map_req = 1'b1;
      end
      if (i == 0) begin
        tests++; if ({bg2_dout, map_dout} !== {16'h1111, 16'h0000}) begin fails++; $display("FAIL rr_dout_0: got %h/%h expected 1111/0000", bg2_dout, map_dout); end
      end
    end
    tests++; if ({bg2_dout, map_dout} !== {16'h3333, 16'h2222}) begin fails++; $display("FAIL rr_dout_final: got %h/%h expected 3333/2222", bg2_dout, map_dout); end
    repeat (2) @(negedge CLK);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rr_idle: got busy=%b expected 0", busy); end
  endtask

  task automatic test_stray_ready();
    do_reset();
    pulse_ready(16'h9999);
    tests++; if ({busy, rom_rdy, bg2_rdy, map_rdy} !== 4'b0000) begin fails++; $display("FAIL stray_ready: got busy/rdys=%b expected 0000", {busy, rom_rdy, bg2_rdy, map_rdy}); end
    @(negedge CLK);
    tests++; if ({busy, bg2_dout, map_dout} !== 33'h0) begin fails++; $display("FAIL stray_state: got busy=%b dout=%h/%h expected 0/0000/0000", busy, bg2_dout, map_dout); end
  endtask

  task automatic test_download_mid_op();
    int n;
    do_reset();
    bg2_req = 1'b1;
    wait_ch3_req(n);
    @(negedge CLK);
    download = 1'b1; rom_req = 1'b1; rom_addr = 25'h0000010; rom_din = 16'hBEEF; rom_be = 2'b01;
    @(negedge CLK);
    tests++; if ({ch3_rnw, ch3_addr} !== {1'b1, 24'h000080}) begin fails++; $display("FAIL mid_hold: got rnw=%b addr=%h expected 1/000080", ch3_rnw, ch3_addr); end
    pulse_ready(16'h4444);
    tests++; if ({rom_rdy, bg2_rdy, bg2_dout} !== {2'b01, 16'h4444}) begin fails++; $display("FAIL mid_bg2_done: got rom=%b bg2=%b dout=%h expected 0/1/4444", rom_rdy, bg2_rdy, bg2_dout); end
    bg2_req = 1'b0;
    wait_ch3_req(n);
    tests++; if ({ch3_rnw, ch3_addr, ch3_din, ch3_be} !== {1'b0, 24'h000008, 16'hBEEF, 2'b01}) begin fails++; $display("FAIL mid_rom_grant: got %b/%h/%h/%b expected 0/000008/beef/01", ch3_rnw, ch3_addr, ch3_din, ch3_be); end
    @(negedge CLK);
    pulse_ready(16'h0000);
    tests++; if ({rom_rdy, bg2_dout} !== {1'b1, 16'h4444}) begin fails++; $display("FAIL mid_rom_done: got rdy=%b bg2_dout=%h expected 1/4444", rom_rdy, bg2_dout); end
    rom_req = 1'b0; download = 1'b0;
  endtask

  task automatic test_dbg_mask();
    int n;
    logic bg2_seen;
    do_reset();
    dbg_mask = 2'b01; bg2_req = 1'b1; map_req = 1'b1;
    bg2_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      wait_ch3_req(n);
      tests++; if ({n < 0, ch3_addr} !== {1'b0, 24'h000100}) begin fails++; $display("FAIL mask_grant_%0d: got n=%0d addr=%h expected MAP 000100", i, n, ch3_addr); end
      @(negedge CLK);
      pulse_ready(16'hA000 + 16'(i));
      bg2_seen |= bg2_rdy;
      tests++; if ({map_rdy, map_dout} !== {1'b1, 16'hA000 + 16'(i)}) begin fails++; $display("FAIL mask_map_%0d: got rdy=%b dout=%h expected 1/%h", i, map_rdy, map_dout, 16'hA000 + 16'(i)); end
      map_req = 1'b0;
      @(negedge CLK);
      map_req = (i != 2);
    end
    tests++; if (bg2_seen !== 1'b0) begin fails++; $display("FAIL mask_bg2_blocked: got bg2_rdy seen=%b expected 0", bg2_seen); end
    dbg_mask = 2'b00;
    wait_ch3_req(n);
    tests++; if ({n < 0, ch3_addr} !== {1'b0, 24'h000080}) begin fails++; $display("FAIL mask_clear_grant: got n=%0d addr=%h expected BG2 000080", n, ch3_addr); end
    @(negedge CLK);
    pulse_ready(16'hB0B0);
    tests++; if ({bg2_rdy, bg2_dout} !== {1'b1, 16'hB0B0}) begin fails++; $display("FAIL mask_clear_done: got %b/%h expected 1/b0b0", bg2_rdy, bg2_dout); end
    bg2_req = 1'b0;
  endtask

  task automatic test_drop_and_mask_inflight();
    int n;
    do_reset();
    bg2_req = 1'b1;
    wait_ch3_req(n);
    bg2_req = 1'b0; dbg_mask = 2'b01;
    @(negedge CLK);
    pulse_ready(16'h5555);
    tests++; if ({bg2_rdy, bg2_dout} !== {1'b1, 16'h5555}) begin fails++; $display("FAIL drop_completes: got %b/%h expected 1/5555", bg2_rdy, bg2_dout); end
    dbg_mask = 2'b00;
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    bg2_req = 1'b1;
    wait_ch3_req(n);
    @(negedge CLK);
    RSTn = 1'b0; bg2_req = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    tests++; if ({busy, ch3_rnw} !== 2'b01) begin fails++; $display("FAIL rstmid_idle: got busy=%b rnw=%b expected 0/1", busy, ch3_rnw); end
    pulse_ready(16'h7777);
    tests++; if ({busy, bg2_rdy, bg2_dout} !== {2'b00, 16'h0000}) begin fails++; $display("FAIL rstmid_ready_ignored: got %b/%b/%h expected 0/0/0000", busy, bg2_rdy, bg2_dout); end
  endtask

  task automatic test_timeout();
`ifdef SDR_CH3_TIMEOUT_EN
    int n;
    int cyc;
    do_reset();
    bg2_req = 1'b1;
    wait_ch3_req(n);
    cyc = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge CLK);
      if (bg2_rdy === 1'b1) begin
        cyc = i;
        break;
      end
    end
    tests++; if (cyc !== 17) begin fails++; $display("FAIL to_rdy_cycle: got %0d expected 17", cyc); end
    tests++; if ({bg2_dout, err} !== {16'hFFFF, 1'b1}) begin fails++; $display("FAIL to_fill_err: got %h/%b expected ffff/1", bg2_dout, err); end
    bg2_req = 1'b0;
    @(negedge CLK);
    pulse_ready(16'h1234);
    tests++; if ({busy, bg2_rdy, err, bg2_dout} !== {3'b001, 16'hFFFF}) begin fails++; $display("FAIL to_late_ready: got %b/%b/%b/%h expected 0/0/1/ffff", busy, bg2_rdy, err, bg2_dout); end
    do_reset();
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL to_err_clear: got %b expected 0", err); end
`else
    int n;
    do_reset();
    bg2_req = 1'b1;
    wait_ch3_req(n);
    repeat (40) @(negedge CLK);
    tests++; if ({busy, bg2_rdy, err} !== 3'b100) begin fails++; $display("FAIL no_to_wait: got busy/rdy/err=%b expected 100", {busy, bg2_rdy, err}); end
    bg2_req = 1'b0;
    pulse_ready(16'h2468);
    tests++; if ({bg2_rdy, bg2_dout} !== {1'b1, 16'h2468}) begin fails++; $display("FAIL no_to_done: got %b/%h expected 1/2468", bg2_rdy, bg2_dout); end
`endif
  endtask

  initial begin
    test_reset();
    test_download_write();
    test_round_robin();
    test_stray_ready();
    test_download_mid_op();
    test_dbg_mask();
    test_drop_and_mask_inflight();
    test_reset_mid();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sdr_ch3_arbiter.md
Name: sdr_ch3_arbiter

Overview:
- Sequences SDRAM channel 3, which is shared by three requesters: ROM-download writes, BG2 tile reads and tilemap (MAP) reads.
- Sits between rom_loader / XSleenaCore and the sdram ch3 port, and replaces the ad-hoc download mux at top level.
- Serves one transaction at a time:
  - the ROM writer has absolute priority while a download is active;
  - BG2 and MAP are round-robin arbitrated otherwise.

Parameters:
AW, 25, requester byte-address width; the ch3 word address is AW-1 bits (addr[AW-1:1])
TIMEOUT, 255, watchdog cycle limit (used only with SDR_CH3_TIMEOUT_EN)

Ports:
CLK  in  1  system clock, the same clock as the sdram ch3 interface
RSTn  in  1  reset, synchronous, active-low
download  in  1  ROM download active (ioctl_download && ioctl_index==0)
rom_addr  in  AW  ROM write byte address
rom_din  in  16  ROM write data
rom_be  in  2  ROM byte enables
rom_req  in  1  ROM request, level, held until rom_rdy
rom_rdy  out  1  one-cycle write-complete pulse
bg2_addr  in  AW  BG2 read byte address
bg2_req  in  1  BG2 request, level
bg2_dout  out  16  BG2 read data, valid while bg2_rdy=1 and held afterwards
bg2_rdy  out  1  one-cycle completion pulse
map_addr  in  AW  MAP read byte address
map_req  in  1  MAP request, level
map_dout  out  16  MAP read data, held
map_rdy  out  1  one-cycle completion pulse
dbg_mask  in  2  bit0 blocks BG2 requests, bit1 blocks MAP requests
ch3_addr  out  AW-1  SDRAM word address
ch3_din  out  16  SDRAM write data
ch3_be  out  2  SDRAM byte enables
ch3_rnw  out  1  1 = read, 0 = write
ch3_req  out  1  one-cycle request pulse
ch3_dout  in  16  SDRAM read data
ch3_ready  in  1  SDRAM completion pulse
busy  out  1  high in any state other than IDLE
err  out  1  sticky timeout flag (0 when the macro is absent)

Behaviour:
Reset (RSTn=0 at a CLK edge):
- state=IDLE; every output 0; ch3_rnw=1; round-robin pointer = BG2.

States: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.

IDLE: sample the eligible requests.
- download=1: only rom_req is eligible; BG2 and MAP stay pending and are not acknowledged.
- download=0: bg2_req&~dbg_mask[0] and map_req&~dbg_mask[1] are eligible; rom_req is ignored.
- Both reads eligible: grant the one the pointer selects; after each read grant the pointer moves to the other requester.
- On a grant, latch the channel ID plus addr[AW-1:1], din, be and rnw into ch3_* registers, then go to ISSUE.

ISSUE: ch3_req=1 for exactly this cycle; go to WAIT.
- Latency: a request sampled at edge n gives ch3_req high during cycle n+1.

WAIT: ch3_* are held stable.
- When ch3_ready=1, capture ch3_dout into the granted requester's dout register (reads only) and go to DONE.

DONE: the granted requester's rdy=1 for one cycle, with dout valid in that same cycle; go to IDLE.
- The granted requester must drop req in its rdy cycle.
- The arbiter does not sample requests in DONE, so a stale level cannot double-issue.
- Minimum turnaround is 4 cycles plus the SDRAM latency.

Boundary conditions:
- download falling or rising mid-transaction: the in-flight transaction completes normally; eligibility changes only take effect in IDLE.
- ch3_ready in IDLE, ISSUE or DONE (stray, e.g. after reset): ignored.
- Request dropped before its rdy: the transaction still completes and rdy still pulses; no abort.
- dbg_mask asserted while that channel is in flight: the transaction completes; only new grants are blocked.
- Reset mid-transaction: return to IDLE immediately; the outstanding SDRAM ready is ignored.
- Non-granted dout registers are never modified.

Optional Feature:
SDR_CH3_TIMEOUT_EN
- Defined:
  - a counter runs in WAIT;
  - if TIMEOUT cycles pass without ch3_ready, capture 16'hFFFF as read data, set err (sticky until reset) and go to DONE, pulsing rdy normally;
  - a late ch3_ready is then ignored as stray.
- Undefined:
  - no counter; WAIT waits indefinitely;
  - err is tied to 0.

Decomposition:
- xain_pkg holds:
  - the enum sdr_ch3_state_t {IDLE, ISSUE, WAIT, DONE};
  - the enum sdr_ch3_id_t {CH3_ROM, CH3_BG2, CH3_MAP};
  - the constant SDR_CH3_TIMEOUT_FILL = 16'hFFFF.
- Single module; no sub-module. The round-robin pick is a few lines of the IDLE decode.

Test Plan:
1. Download write: download=1, rom_addr=25'h0001234, rom_din=16'hA55A, rom_be=2'b11, rom_req=1 -> next cycle ch3_req=1, ch3_addr=24'h00091A, ch3_rnw=0, ch3_be=2'b11, ch3_din=16'hA55A; ch3_ready 5 cycles later -> rom_rdy pulses exactly 1 cycle after ch3_ready; bg2_req held throughout gets no bg2_rdy.
2. Round robin: download=0, bg2_req and map_req both held, ch3_ready returns 16'h1111, 16'h2222, 16'h3333 -> grant order BG2, MAP, BG2; bg2_dout=16'h1111 then 16'h3333; map_dout=16'h2222.
3. Stray ready: pulse ch3_ready in IDLE after reset -> no rdy output, busy stays 0, state stays IDLE.
4. Mid-op download change: BG2 read in WAIT, download goes 0->1 with rom_req=1 -> BG2 read completes with bg2_rdy; next grant goes to ROM.
5. Debug mask: dbg_mask=2'b01, bg2_req=1, map_req=1 -> only MAP is granted, repeatedly; BG2 is never acknowledged until the mask clears.
6. Timeout (macro defined, TIMEOUT=16): read with no ch3_ready -> bg2_rdy pulses at WAIT entry + 16 cycles, bg2_dout=16'hFFFF, err=1; a later ch3_ready is ignored; err clears only on RSTn=0.
